// File: rtl/frame_line_padder.sv
// Appends PAD_LINES full-width lines after each video frame on an AXI4-Stream path.
// Define FRAME_LINE_PADDER_REPLICATE_EN to pad with the last input line instead of PAD_VALUE.
module frame_line_padder #(
  parameter int unsigned           FRAME_RES_X = 1920,
  parameter int unsigned           PX_WIDTH    = 10,
  parameter int unsigned           PAD_LINES   = 2,
  parameter logic [PX_WIDTH-1:0]   PAD_VALUE   = '0,
  parameter int unsigned           ID_WIDTH    = 4,
  parameter int unsigned           DEST_WIDTH  = 4,
  localparam int unsigned          TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
  localparam int unsigned          TSTRB_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  // Upstream video
  input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic [TSTRB_WIDTH-1:0]   video_i_tstrb,
  input  logic [TSTRB_WIDTH-1:0]   video_i_tkeep,
  input  logic [ID_WIDTH-1:0]      video_i_tid,
  input  logic [DEST_WIDTH-1:0]    video_i_tdest,
  input  logic                     video_i_tuser,
  input  logic                     video_i_tlast,
  input  logic                     video_i_tvalid,
  output logic                     video_i_tready,
  input  logic                     eof_i,
  // Extended video
  output logic [TDATA_WIDTH-1:0]   video_o_tdata,
  output logic [TSTRB_WIDTH-1:0]   video_o_tstrb,
  output logic [TSTRB_WIDTH-1:0]   video_o_tkeep,
  output logic [ID_WIDTH-1:0]      video_o_tid,
  output logic [DEST_WIDTH-1:0]    video_o_tdest,
  output logic                     video_o_tuser,
  output logic                     video_o_tlast,
  output logic                     video_o_tvalid,
  input  logic                     video_o_tready,
  output logic                     eof_o,
  output logic                     pad_active_o
);

  localparam int unsigned PX_CNT_W = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int unsigned LN_CNT_W = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;
  localparam bit          PAD_EN   = (PAD_LINES > 0);
  localparam logic [PX_CNT_W-1:0] LAST_PX   = PX_CNT_W'(FRAME_RES_X - 1);
  localparam logic [LN_CNT_W-1:0] LAST_LINE = LN_CNT_W'(PAD_EN ? PAD_LINES - 1 : 0);

  typedef enum logic {
    StPass = 1'b0,
    StPad  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [PX_CNT_W-1:0]   r_px_cnt;
  logic [PX_CNT_W-1:0]   w_px_cnt_next;
  logic [LN_CNT_W-1:0]   r_line_cnt;
  logic [LN_CNT_W-1:0]   w_line_cnt_next;
  logic [PX_WIDTH-1:0]   w_pad_px;
  logic                  w_in_hs;
  logic                  w_pad_hs;
  logic                  w_pad_tlast;
  logic                  w_last_line;

  assign w_in_hs     = rst_n_i && (r_state == StPass) && video_i_tvalid && video_o_tready;
  assign w_pad_hs    = rst_n_i && (r_state == StPad) && video_o_tready;
  assign w_pad_tlast = (r_px_cnt == LAST_PX);
  assign w_last_line = (r_line_cnt == LAST_LINE);

`ifdef FRAME_LINE_PADDER_REPLICATE_EN
  // Every accepted pass beat lands at its in-line index; pad reads back by pixel counter.
  logic [PX_WIDTH-1:0] r_line_buf [FRAME_RES_X];
  logic [PX_CNT_W-1:0] r_wr_idx;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_idx <= '0;
      for (int unsigned i = 0; i < FRAME_RES_X; i++) begin
        r_line_buf[i] <= '0;
      end
    end else if (w_in_hs) begin
      r_line_buf[r_wr_idx] <= video_i_tdata[PX_WIDTH-1:0];
      if (video_i_tlast || (r_wr_idx == LAST_PX)) begin
        r_wr_idx <= '0;
      end else begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
    end
  end

  assign w_pad_px = r_line_buf[r_px_cnt];
`else
  assign w_pad_px = PAD_VALUE;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= StPass;
      r_px_cnt   <= '0;
      r_line_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_px_cnt   <= w_px_cnt_next;
      r_line_cnt <= w_line_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_px_cnt_next   = r_px_cnt;
    w_line_cnt_next = r_line_cnt;
    video_o_tdata   = '0;
    video_o_tstrb   = '0;
    video_o_tkeep   = '0;
    video_o_tid     = '0;
    video_o_tdest   = '0;
    video_o_tuser   = 1'b0;
    video_o_tlast   = 1'b0;
    video_o_tvalid  = 1'b0;
    video_i_tready  = 1'b0;
    eof_o           = 1'b0;
    pad_active_o    = 1'b0;

    case (r_state)
      StPass: begin
        // Zero-latency bypass; reset gates the handshake signals combinationally.
        video_o_tdata  = video_i_tdata;
        video_o_tstrb  = video_i_tstrb;
        video_o_tkeep  = video_i_tkeep;
        video_o_tid    = video_i_tid;
        video_o_tdest  = video_i_tdest;
        video_o_tuser  = video_i_tuser;
        video_o_tlast  = video_i_tlast;
        video_o_tvalid = rst_n_i && video_i_tvalid;
        video_i_tready = rst_n_i && video_o_tready;
        eof_o          = !PAD_EN && rst_n_i && video_i_tvalid && video_i_tlast && eof_i;
        if (PAD_EN && w_in_hs && video_i_tlast && eof_i) begin
          w_state_next = StPad;
        end
      end

      StPad: begin
        video_o_tdata  = TDATA_WIDTH'(w_pad_px);
        video_o_tstrb  = '1;
        video_o_tkeep  = '1;
        video_o_tlast  = w_pad_tlast;
        video_o_tvalid = rst_n_i;
        eof_o          = rst_n_i && w_pad_tlast && w_last_line;
        pad_active_o   = rst_n_i;
        if (w_pad_hs) begin
          if (w_pad_tlast) begin
            w_px_cnt_next = '0;
            if (w_last_line) begin
              w_line_cnt_next = '0;
              w_state_next    = StPass;
            end else begin
              w_line_cnt_next = r_line_cnt + 1'b1;
            end
          end else begin
            w_px_cnt_next = r_px_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = StPass;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_line_padder.sv
// Randomized self-checking bench for frame_line_padder against a frame-level reference model.
module tb_frame_line_padder;

  localparam int unsigned FRX  = 4;
  localparam int unsigned PXW  = 10;
  localparam int unsigned PADL = 2;
  localparam int unsigned TDW  = 16;
  localparam int unsigned SW   = 2;
  localparam logic [PXW-1:0] PAD_VAL = 10'h3FF;

  typedef struct packed {
    logic           user;
    logic           last;
    logic           eof;
    logic [3:0]     id;
    logic [3:0]     dest;
    logic [SW-1:0]  keep;
    logic [SW-1:0]  strb;
    logic [TDW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [TDW-1:0] in_tdata = '0;
  logic [SW-1:0]  in_tstrb = '0, in_tkeep = '0;
  logic [3:0]     in_tid = '0, in_tdest = '0;
  logic           in_tuser = 1'b0, in_tlast = 1'b0, in_tvalid = 1'b0, eof_in = 1'b0;
  logic           in_tready;
  logic [TDW-1:0] out_tdata;
  logic [SW-1:0]  out_tstrb, out_tkeep;
  logic [3:0]     out_tid, out_tdest;
  logic           out_tuser, out_tlast, out_tvalid, eof_out, pad_active;
  logic           out_tready = 1'b1;

  logic [TDW-1:0] z_in_tdata = '0;
  logic [SW-1:0]  z_in_tstrb = '0, z_in_tkeep = '0;
  logic [3:0]     z_in_tid = '0, z_in_tdest = '0;
  logic           z_in_tuser = 1'b0, z_in_tlast = 1'b0, z_in_tvalid = 1'b0, z_eof_in = 1'b0;
  logic           z_in_tready;
  logic [TDW-1:0] z_out_tdata;
  logic [SW-1:0]  z_out_tstrb, z_out_tkeep;
  logic [3:0]     z_out_tid, z_out_tdest;
  logic           z_out_tuser, z_out_tlast, z_out_tvalid, z_eof_out, z_pad_active;
  logic           z_out_tready = 1'b1;

  frame_line_padder #(
    .FRAME_RES_X(FRX), .PX_WIDTH(PXW), .PAD_LINES(PADL), .PAD_VALUE(PAD_VAL),
    .ID_WIDTH(4), .DEST_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .video_i_tdata(in_tdata), .video_i_tstrb(in_tstrb), .video_i_tkeep(in_tkeep),
    .video_i_tid(in_tid), .video_i_tdest(in_tdest), .video_i_tuser(in_tuser),
    .video_i_tlast(in_tlast), .video_i_tvalid(in_tvalid), .video_i_tready(in_tready),
    .eof_i(eof_in),
    .video_o_tdata(out_tdata), .video_o_tstrb(out_tstrb), .video_o_tkeep(out_tkeep),
    .video_o_tid(out_tid), .video_o_tdest(out_tdest), .video_o_tuser(out_tuser),
    .video_o_tlast(out_tlast), .video_o_tvalid(out_tvalid), .video_o_tready(out_tready),
    .eof_o(eof_out), .pad_active_o(pad_active)
  );

  frame_line_padder #(
    .FRAME_RES_X(FRX), .PX_WIDTH(PXW), .PAD_LINES(0), .PAD_VALUE(PAD_VAL),
    .ID_WIDTH(4), .DEST_WIDTH(4)
  ) dut_nopad (
    .clk_i(clk), .rst_n_i(rst_n),
    .video_i_tdata(z_in_tdata), .video_i_tstrb(z_in_tstrb), .video_i_tkeep(z_in_tkeep),
    .video_i_tid(z_in_tid), .video_i_tdest(z_in_tdest), .video_i_tuser(z_in_tuser),
    .video_i_tlast(z_in_tlast), .video_i_tvalid(z_in_tvalid), .video_i_tready(z_in_tready),
    .eof_i(z_eof_in),
    .video_o_tdata(z_out_tdata), .video_o_tstrb(z_out_tstrb), .video_o_tkeep(z_out_tkeep),
    .video_o_tid(z_out_tid), .video_o_tdest(z_out_tdest), .video_o_tuser(z_out_tuser),
    .video_o_tlast(z_out_tlast), .video_o_tvalid(z_out_tvalid), .video_o_tready(z_out_tready),
    .eof_o(z_eof_out), .pad_active_o(z_pad_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int pad_hs_cnt = 0;
  bit rand_ready = 1'b0;
  bit gap_en = 1'b0;
  bit mon_en = 1'b0;

  beat_t in_q[$];
  beat_t exp_q[$];
  bit    pad_q[$];
  logic [PXW-1:0] line_mem [FRX];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: input beats pass unchanged, then PADL full lines of pad pixels.
  task automatic build_frame(input int nlines, input bit directed);
    beat_t b;
    beat_t e;
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = directed ? int'(FRX) : int'($urandom_range(1, FRX));
      for (int n = 0; n < len; n++) begin
        if (directed) begin
          b.data = (l == nlines - 1) ? 16'h10 + 16'(n) : 16'(l * 4 + n + 1);
          b.strb = '1; b.keep = '1; b.id = 4'(l); b.dest = 4'h0;
        end else begin
          b.data = 16'($urandom);
          b.strb = 2'($urandom); b.keep = 2'($urandom);
          b.id = 4'($urandom); b.dest = 4'($urandom);
        end
        b.user = (l == 0) && (n == 0);
        b.last = (n == len - 1);
        b.eof  = (l == nlines - 1) && b.last;
        in_q.push_back(b);
        e = b;
        e.eof = 1'b0;
        exp_q.push_back(e);
        pad_q.push_back(1'b0);
        line_mem[n] = b.data[PXW-1:0];
      end
    end
    for (int l = 0; l < int'(PADL); l++) begin
      for (int n = 0; n < int'(FRX); n++) begin
`ifdef FRAME_LINE_PADDER_REPLICATE_EN
        e.data = 16'(line_mem[n]);
`else
        e.data = 16'(PAD_VAL);
`endif
        e.strb = '1; e.keep = '1; e.id = '0; e.dest = '0; e.user = 1'b0;
        e.last = (n == int'(FRX) - 1);
        e.eof  = e.last && (l == int'(PADL) - 1);
        exp_q.push_back(e);
        pad_q.push_back(1'b1);
      end
    end
  endtask

  task automatic send_beat(input beat_t b);
    int n;
    bit acc;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        in_tvalid = 1'b0;
        eof_in = 1'($urandom);
        in_tlast = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_tdata = b.data; in_tstrb = b.strb; in_tkeep = b.keep; in_tid = b.id; in_tdest = b.dest;
    in_tuser = b.user; in_tlast = b.last; eof_in = b.eof; in_tvalid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check_eq("in_accept_timeout", 64'(acc), 64'd1);
    in_tvalid = 1'b0;
    eof_in = 1'b0;
  endtask

  task automatic send_all();
    beat_t b;
    while (in_q.size() > 0) begin
      b = in_q.pop_front();
      send_beat(b);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output sink
  initial begin
    forever begin
      @(posedge clk); #1;
      out_tready = rand_ready ? 1'($urandom) : 1'b1;
    end
  end

  // Output monitor: ordered compare against the model, plus AXI hold-while-stalled.
  initial begin
    beat_t obs;
    beat_t prev_obs;
    beat_t e;
    bit p;
    bit prev_stall = 1'b0;
    prev_obs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        obs.user = out_tuser; obs.last = out_tlast; obs.eof = eof_out; obs.id = out_tid;
        obs.dest = out_tdest; obs.keep = out_tkeep; obs.strb = out_tstrb; obs.data = out_tdata;
        if (prev_stall) check_eq("hold", 64'(obs), 64'(prev_obs));
        if (pad_active) check_eq("pad_no_bubble", 64'(out_tvalid), 64'd1);
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            p = pad_q.pop_front();
            check_eq("beat", 64'(obs), 64'(e));
            check_eq("pad_active", 64'(pad_active), 64'(p));
            if (p) begin
              check_eq("in_tready_in_pad", 64'(in_tready), 64'd0);
              pad_hs_cnt++;
            end
          end
        end
        prev_stall = out_tvalid && !out_tready;
        prev_obs = obs;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t zb;
    beat_t zo;
    int n;
    for (int i = 0; i < int'(FRX); i++) line_mem[i] = '0;

    // Reset: handshake outputs must be held low even with input activity.
    in_tvalid = 1'b1; in_tlast = 1'b1; eof_in = 1'b1;
    z_in_tvalid = 1'b1; z_in_tlast = 1'b1; z_eof_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check_eq("rst_in_tready", 64'(in_tready), 64'd0);
    check_eq("rst_eof", 64'(eof_out), 64'd0);
    check_eq("rst_pad_active", 64'(pad_active), 64'd0);
    check_eq("rst_z_out_tvalid", 64'(z_out_tvalid), 64'd0);
    check_eq("rst_z_eof", 64'(z_eof_out), 64'd0);
    in_tvalid = 1'b0; in_tlast = 1'b0; eof_in = 1'b0;
    z_in_tvalid = 1'b0; z_in_tlast = 1'b0; z_eof_in = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // No-pad instance: pure bypass, eof_o on the frame's last beat.
    for (int i = 0; i < 8; i++) begin
      zb.data = 16'($urandom); zb.strb = 2'($urandom); zb.keep = 2'($urandom);
      zb.id = 4'($urandom); zb.dest = 4'($urandom);
      zb.user = (i == 0); zb.last = (i % 4 == 3); zb.eof = (i == 7);
      z_in_tdata = zb.data; z_in_tstrb = zb.strb; z_in_tkeep = zb.keep; z_in_tid = zb.id;
      z_in_tdest = zb.dest; z_in_tuser = zb.user; z_in_tlast = zb.last; z_eof_in = zb.eof;
      z_in_tvalid = 1'b1;
      @(negedge clk);
      zo.user = z_out_tuser; zo.last = z_out_tlast; zo.eof = z_eof_out; zo.id = z_out_tid;
      zo.dest = z_out_tdest; zo.keep = z_out_tkeep; zo.strb = z_out_tstrb; zo.data = z_out_tdata;
      check_eq("nopad_beat", 64'(zo), 64'(zb));
      check_eq("nopad_tready", 64'(z_in_tready), 64'd1);
      check_eq("nopad_pad_active", 64'(z_pad_active), 64'd0);
      @(posedge clk); #1;
    end
    z_in_tvalid = 1'b0; z_eof_in = 1'b0;

    // Directed: two 3-line frames back to back, second SOF offered during pad.
    mon_en = 1'b1;
    rand_ready = 1'b0;
    gap_en = 1'b0;
    pad_hs_cnt = 0;
    build_frame(3, 1'b1);
    build_frame(3, 1'b1);
    send_all();
    drain("directed_drain");
    check_eq("directed_pad_beats", 64'(pad_hs_cnt), 64'd16);

    // Random frames, random back-pressure and input gaps.
    rand_ready = 1'b1;
    gap_en = 1'b1;
    for (int f = 0; f < 25; f++) begin
      build_frame(int'($urandom_range(1, 3)), 1'b0);
      send_all();
    end
    drain("random_drain");

    // Reset during the third pad beat.
    rand_ready = 1'b0;
    gap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pad_hs_cnt = 0;
    build_frame(2, 1'b0);
    send_all();
    n = 0;
    while (pad_hs_cnt < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_eq("pad_before_reset", 64'(pad_active), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midpad_rst_tvalid", 64'(out_tvalid), 64'd0);
    check_eq("midpad_rst_pad_active", 64'(pad_active), 64'd0);
    check_eq("midpad_rst_eof", 64'(eof_out), 64'd0);
    exp_q.delete();
    pad_q.delete();
    in_q.delete();
    for (int i = 0; i < int'(FRX); i++) line_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("no_residual_tvalid", 64'(out_tvalid), 64'd0);
    check_eq("no_residual_pad", 64'(pad_active), 64'd0);
    @(posedge clk); #1;
    pad_hs_cnt = 0;
    build_frame(2, 1'b0);
    send_all();
    drain("post_reset_drain");
    check_eq("post_reset_pad_beats", 64'(pad_hs_cnt), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_line_padder.md
FRAME_LINE_PADDER -- requirements
Module: frame_line_padder

Interface
REQ-001 SHALL have parameter FRAME_RES_X, default 1920, pixels per line (padded line length).
REQ-002 SHALL have parameter PX_WIDTH, default 10, pixel bits; TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8.
REQ-003 SHALL have parameter PAD_LINES, default 2, lines appended after each frame; 0 is legal.
REQ-004 SHALL have parameter PAD_VALUE, default 0, PX_WIDTH-bit constant pad pixel.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_n_i, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port video_i, axi4_stream_if slave, TDATA_WIDTH/TUSER 1, upstream video with frame-end line.
REQ-008 SHALL have port eof_i, input, 1 bit, high while the current video_i beat is the last beat of a frame.
REQ-009 SHALL have port video_o, axi4_stream_if master, same widths, extended video.
REQ-010 SHALL have port eof_o, input-qualified output, 1 bit, marks the last beat of the extended frame.
REQ-011 SHALL have port pad_active_o, output, 1 bit, high in PAD state.

Function
REQ-012 SHALL implement FSM with states PASS and PAD; PASS after reset.
REQ-013 In PASS: video_o = video_i combinationally (all sideband fields), video_i.tready = video_o.tready, zero latency.
REQ-014 PASS->PAD SHALL occur on the clock edge where video_i.tvalid, tready, tlast and eof_i are all high and PAD_LINES > 0; eof_i without completed handshake SHALL be ignored.
REQ-015 In PAD: video_i.tready = 0, video_o.tvalid = 1 every cycle (no bubbles), tuser = 0, tstrb/tkeep all ones, tid/tdest = 0.
REQ-016 Pixel counter (width $clog2(FRAME_RES_X)) SHALL advance on each video_o handshake in PAD; tlast = 1 when counter = FRAME_RES_X-1, then counter wraps to 0.
REQ-017 Line counter (width $clog2(PAD_LINES+1)) SHALL increment on each tlast handshake in PAD; PAD->PASS on the handshake of tlast of line PAD_LINES, counters cleared.
REQ-018 Outputs SHALL hold stable while video_o.tvalid high and tready low (AXI4-Stream rule).
REQ-019 eof_o SHALL equal video_o.tvalid && tlast in PAD on the final padded line; if PAD_LINES = 0, eof_o SHALL equal video_i.tvalid && tlast && eof_i in PASS.
REQ-020 eof_o SHALL be 0 in PASS whenever PAD_LINES > 0.
REQ-021 Back-to-back frames: a frame's SOF beat arriving while in PAD SHALL be stalled (tready 0) until return to PASS, then passed unchanged.
REQ-022 Input lines shorter than FRAME_RES_X SHALL be passed unmodified; padded lines are always FRAME_RES_X beats.

Reset
REQ-023 While rst_n_i low: state PASS, both counters 0, video_o.tvalid 0, video_i.tready 0, eof_o 0, pad_active_o 0.
REQ-024 Reset asserted mid-PAD SHALL abort padding immediately; after release the block starts in PASS with no residual pad beats.

Configuration
REQ-025 Macro FRAME_LINE_PADDER_REPLICATE_EN SHALL select pad content.
REQ-026 Defined: a FRAME_RES_X-entry PX_WIDTH line buffer SHALL capture every PASS-state input beat at its in-line index (write counter reset on tlast); pad pixel N = buffer[N], i.e. last input line replicated; entries beyond a short line's length keep older contents; buffer reset contents 0; read path SHALL add no bubbles.
REQ-027 Not defined: pad pixels = PAD_VALUE, no line buffer instantiated.

Verification
REQ-028 FRAME_RES_X=4, PAD_LINES=2, 3-line frame, tready always 1 -> 12 pass beats then 8 pad beats, tlast at beats 4/8 of pad, eof_o only on beat 20.
REQ-029 Same, random tready 50% -> no data change while stalled, identical beat sequence, video_i.tready 0 for all 8 pad beats.
REQ-030 PAD_LINES=0, eof_i on last beat -> output equals input, eof_o on that beat, pad_active_o never high.
REQ-031 Next frame SOF offered on first pad cycle -> stalled exactly until 8th pad handshake, then passed with tuser 1.
REQ-032 rst_n_i pulsed low during pad beat 3 -> tvalid 0 immediately; after release, new frame passes with no leftover pad beats.
REQ-033 REPLICATE_EN, last line 0x10,0x11,0x12,0x13 -> both pad lines carry 0x10..0x13; without macro, PAD_VALUE=0x3FF -> all pad beats 0x3FF.
